fetch_inst_queue: RTL and testbench
===================================

// Module: fetch_inst_queue
// PURPOSE
// - Decoupling instruction queue between decode and rename; consumes the per-lane decoded packets of the fetch-2/decode path.
// - Compacts sparse valid lanes into a circular buffer; releases whole DISPATCH_WIDTH bundles to rename.
// - Produces the back-pressure flag that stalls the fetch-1/fetch-2 pipeline registers and fetch-2 itself.
// PARAMETERS
// - FETCH_WIDTH     4   write lanes per cycle
// - DISPATCH_WIDTH  4   read lanes per cycle; a bundle is released only when complete
// - DEPTH           32  entries; power of 2, >= FETCH_WIDTH + DISPATCH_WIDTH
// - PKT_W           64  bits per stored packet (opaque payload)
// PORTS
// - clk          in   1                   clock; all state updates on the rising edge
// - reset        in   1                   asynchronous, active-low
// - flush_i      in   1                   recovery/exception/fetch reset; discard all contents
// - wr_valid_i   in   FETCH_WIDTH         per-lane valid from decode (may be sparse)
// - wr_pkt_i     in   FETCH_WIDTH*PKT_W   lane i packet at bits [i*PKT_W +: PKT_W]
// - full_o       out  1                   buffer full; upstream must hold its bundle
// - rd_stall_i   in   1                   rename not ready
// - rd_valid_o   out  1                   DISPATCH_WIDTH packets presented this cycle
// - rd_pkt_o     out  DISPATCH_WIDTH*PKT_W  oldest packet in slot 0
// - count_o      out  $clog2(DEPTH)+1     current occupancy
// BEHAVIOUR
// - State: head and tail pointers (log2 DEPTH bits, modulo DEPTH); count (log2 DEPTH + 1 bits); storage array.
// - Reset (reset = 0, async): head = tail = count = 0; full_o = 0; rd_valid_o = 0; count_o = 0. Storage is not reset.
// - full_o = (DEPTH - count) < FETCH_WIDTH. Derived from registered count only; no combinational path from wr_valid_i or rd_stall_i.
// - Write accept: wr_en = !full_o & !flush_i & |wr_valid_i.
//   - Ignored lanes: writes presented while full_o = 1 are dropped. Upstream holds the bundle and re-presents it.
// - Compaction: the k-th set bit of wr_valid_i (lane order, 0 first) is written to entry (tail + k) mod DEPTH.
//   - tail += popcount(wr_valid_i).
//   - Sparse patterns such as 4'b1010 occupy 2 consecutive entries.
// - Read: rd_valid_o = (count >= DISPATCH_WIDTH) & !flush_i.
//   - rd_pkt_o slot j = entry (head + j) mod DEPTH, read combinationally from registered state.
//   - Pop when rd_valid_o & !rd_stall_i: head += DISPATCH_WIDTH.
//   - Partial bundles are never released; they wait for more writes.
// - Count update: count_next = count + (wr_en ? popcount : 0) - (pop ? DISPATCH_WIDTH : 0). Write and pop in the same cycle are both applied.
// - Full evaluation: full_o is evaluated on pre-pop count, so a write is dropped in a full cycle even when a pop also occurs.
// - Wrap-around: pointer arithmetic is modulo DEPTH; writes and reads that straddle entry DEPTH-1 -> 0 are contiguous.
// - Flush: dominates writes and pops in the same cycle. Next edge: head = tail = count = 0. rd_valid_o is 0 during the flush cycle.
// - Reset asserted mid-operation clears state immediately, regardless of clk.
// - Latency: a packet written at edge N is visible on rd_pkt_o after edge N, provided the bundle is complete. Minimum write-to-read is 1 cycle.
// - Assertions: count never exceeds DEPTH; pop never occurs with count < DISPATCH_WIDTH.
// CONFIGURATION
// - INST_QUEUE_STATS_EN defined: adds outputs fullCycles_o [31:0] and stallCycles_o [31:0].
//   - fullCycles_o counts cycles with full_o = 1.
//   - stallCycles_o counts cycles with rd_valid_o & rd_stall_i.
//   - Both saturate at 32'hFFFF_FFFF, clear on reset, and are unaffected by flush_i.
// - INST_QUEUE_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING (FETCH_WIDTH = 4, DISPATCH_WIDTH = 4, DEPTH = 32)
// - Sparse compaction: write 4'b1010 then 4'b0111, rd_stall_i = 0.
//   - Expected: count = 2, then 5.
//   - Bundle {A1, A3, B0, B1} released; count = 1.
// - Fill: hold rd_stall_i = 1 and write full bundles.
//   - Expected: full_o = 1 after count = 29 (free 3 < 4); an extra bundle is dropped and count stays 29.
// - Simultaneous write and pop: at count = 8 write 4 lanes with rd_stall_i = 0.
//   - Expected: count = 8 next cycle; FIFO order preserved.
// - Wrap: head = tail = 30, then write 4 lanes.
//   - Expected: entries 30, 31, 0, 1 filled; rd_pkt_o slot order 30, 31, 0, 1.
// - Flush with concurrent write and pop at count = 12.
//   - Expected: rd_valid_o = 0 that cycle; next cycle count = 0, full_o = 0.
// - Async reset mid-stream, asserted between edges at count = 17.
//   - Expected: count_o = 0 and rd_valid_o = 0 immediately.
//   - With INST_QUEUE_STATS_EN defined: counters read 0.

Source files
------------

// File: rtl/fetch_inst_queue.sv
// Instruction queue between decode and rename: compacts sparse decode lanes into a ring
// buffer and releases whole dispatch bundles. Define INST_QUEUE_STATS_EN for occupancy stats.
module fetch_inst_queue #(
    parameter int FETCH_WIDTH    = 4,
    parameter int DISPATCH_WIDTH = 4,
    parameter int DEPTH          = 32,
    parameter int PKT_W          = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush_i,
    input  logic [FETCH_WIDTH-1:0]          wr_valid_i,
    input  logic [FETCH_WIDTH*PKT_W-1:0]    wr_pkt_i,
    output logic                            full_o,
    input  logic                            rd_stall_i,
    output logic                            rd_valid_o,
    output logic [DISPATCH_WIDTH*PKT_W-1:0] rd_pkt_o,
    output logic [$clog2(DEPTH):0]          count_o
`ifdef INST_QUEUE_STATS_EN
    ,
    output logic [31:0]                     fullCycles_o,
    output logic [31:0]                     stallCycles_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FW_C    = CW'(FETCH_WIDTH);
    localparam logic [CW-1:0] DW_C    = CW'(DISPATCH_WIDTH);
    localparam logic [PW-1:0] DW_P    = PW'(DISPATCH_WIDTH);

    logic [PKT_W-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [CW-1:0]    wr_cnt;
    logic [PW-1:0]    lane_off [FETCH_WIDTH];
    logic             wr_en;
    logic             pop;

    // Each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        wr_cnt = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_off[i] = wr_cnt[PW-1:0];
            wr_cnt      = wr_cnt + CW'(wr_valid_i[i]);
        end
    end

    // full_o depends only on registered count so it can gate the fetch pipeline registers.
    assign full_o     = (DEPTH_C - count) < FW_C;
    assign wr_en      = !full_o && !flush_i && (|wr_valid_i);
    assign rd_valid_o = (count >= DW_C) && !flush_i;
    assign pop        = rd_valid_o && !rd_stall_i;
    assign count_o    = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) tail <= tail + wr_cnt[PW-1:0];
            if (pop)   head <= head + DW_P;
            count <= count + (wr_en ? wr_cnt : '0) - (pop ? DW_C : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (wr_valid_i[i]) mem[tail + lane_off[i]] <= wr_pkt_i[i*PKT_W +: PKT_W];
            end
        end
    end

    for (genvar j = 0; j < DISPATCH_WIDTH; j++) begin : g_rd
        assign rd_pkt_o[j*PKT_W +: PKT_W] = mem[head + PW'(j)];
    end

`ifdef INST_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fullCycles_o  <= '0;
            stallCycles_o <= '0;
        end else begin
            if (full_o && (fullCycles_o != '1))
                fullCycles_o <= fullCycles_o + 32'd1;
            if (rd_valid_o && rd_stall_i && (stallCycles_o != '1))
                stallCycles_o <= stallCycles_o + 32'd1;
        end
    end
`endif

    a_count_max: assert property (@(posedge clk) disable iff (!reset) count <= DEPTH_C);
    a_pop_ok:    assert property (@(posedge clk) disable iff (!reset) !(pop && (count < DW_C)));

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed bench for fetch_inst_queue: the driver pushes expected packets, a negedge
// monitor pops and compares each released bundle; directed checks cover count/full/valid.
module tb_fetch_inst_queue;
    logic         clk = 1'b0;
    logic         reset;
    logic         flush_i;
    logic [3:0]   wr_valid_i;
    logic [255:0] wr_pkt_i;
    logic         full_o;
    logic         rd_stall_i;
    logic         rd_valid_o;
    logic [255:0] rd_pkt_o;
    logic [5:0]   count_o;
`ifdef INST_QUEUE_STATS_EN
    logic [31:0]  fullCycles_o;
    logic [31:0]  stallCycles_o;
`endif

    int           total = 0;
    int           bad   = 0;
    int           tag   = 1;
    logic [63:0]  exp_q [$];
    logic [255:0] mon_exp;

    fetch_inst_queue #(.FETCH_WIDTH(4), .DISPATCH_WIDTH(4), .DEPTH(32), .PKT_W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush_i),
        .wr_valid_i (wr_valid_i),
        .wr_pkt_i   (wr_pkt_i),
        .full_o     (full_o),
        .rd_stall_i (rd_stall_i),
        .rd_valid_o (rd_valid_o),
        .rd_pkt_o   (rd_pkt_o),
        .count_o    (count_o)
`ifdef INST_QUEUE_STATS_EN
        ,
        .fullCycles_o  (fullCycles_o),
        .stallCycles_o (stallCycles_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pkt(input int t, input int lane);
        return {16'hFEED, t[15:0], lane[15:0], 16'hBEEF};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Inputs change one time unit after the rising edge; wr_valid drops back to 0 afterwards.
    task automatic wr(input logic [3:0] v, input logic stall, input bit accept);
        rd_stall_i = stall;
        wr_valid_i = v;
        for (int i = 0; i < 4; i++) wr_pkt_i[i*64 +: 64] = pkt(tag, i);
        if (accept)
            for (int i = 0; i < 4; i++) if (v[i]) exp_q.push_back(pkt(tag, i));
        tag++;
        @(posedge clk); #1;
        wr_valid_i = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (reset && rd_valid_o && !rd_stall_i) begin
            total++;
            if (exp_q.size() < 4) begin
                bad++;
                $display("FAIL pop_underflow: bundle released with %0d packets expected", exp_q.size());
            end else begin
                for (int j = 0; j < 4; j++) mon_exp[j*64 +: 64] = exp_q.pop_front();
                if (rd_pkt_o !== mon_exp) begin
                    bad++;
                    $display("FAIL bundle_data: got %h expected %h", rd_pkt_o, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        flush_i    = 1'b0;
        wr_valid_i = '0;
        wr_pkt_i   = '0;
        rd_stall_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(count_o), 0);
        chk("reset_full", 32'(full_o), 0);
        chk("reset_rd_valid", 32'(rd_valid_o), 0);
        reset = 1'b1;
        idle(1);

        // Sparse compaction: {A1,A3} then {B0,B1,B2}; bundle {A1,A3,B0,B1} leaves.
        wr(4'b1010, 1'b0, 1'b1);
        chk("sparse_count_a", 32'(count_o), 2);
        chk("sparse_partial_hold", 32'(rd_valid_o), 0);
        wr(4'b0111, 1'b0, 1'b1);
        chk("sparse_count_b", 32'(count_o), 5);
        chk("sparse_rd_valid", 32'(rd_valid_o), 1);
        idle(1);
        chk("sparse_count_after_pop", 32'(count_o), 1);

        // Fill from 1 with rename stalled: 25 is not full, 29 is; an extra bundle is dropped.
        for (int b = 0; b < 6; b++) wr(4'b1111, 1'b1, 1'b1);
        chk("fill_count_25", 32'(count_o), 25);
        chk("fill_not_full_25", 32'(full_o), 0);
        wr(4'b1111, 1'b1, 1'b1);
        chk("fill_count_29", 32'(count_o), 29);
        chk("fill_full_29", 32'(full_o), 1);
        wr(4'b1111, 1'b1, 1'b0);
        chk("fill_drop_count", 32'(count_o), 29);
        chk("fill_drop_full", 32'(full_o), 1);

        // Drain six bundles down to 5, top up to 8, then write and pop together.
        rd_stall_i = 1'b0;
        idle(6);
        rd_stall_i = 1'b1;
        chk("drain_count_5", 32'(count_o), 5);
        chk("drain_not_full", 32'(full_o), 0);
        wr(4'b1110, 1'b1, 1'b1);
        chk("topup_count_8", 32'(count_o), 8);
        wr(4'b1111, 1'b0, 1'b1);
        chk("wr_pop_count_8", 32'(count_o), 8);
        idle(2);
        chk("drain_empty", 32'(count_o), 0);

        // Move tail to 30 (head stays bundle-aligned), then write a bundle across 31 -> 0.
        for (int b = 0; b < 5; b++) wr(4'b1111, 1'b1, 1'b1);
        wr(4'b0011, 1'b1, 1'b1);
        chk("wrap_count_22", 32'(count_o), 22);
        wr(4'b1111, 1'b1, 1'b1);
        chk("wrap_count_26", 32'(count_o), 26);
        rd_stall_i = 1'b0;
        idle(6);
        rd_stall_i = 1'b1;
        chk("wrap_count_2", 32'(count_o), 2);
        chk("wrap_partial_hold", 32'(rd_valid_o), 0);
        wr(4'b1100, 1'b0, 1'b1);
        chk("wrap_count_4", 32'(count_o), 4);
        idle(1);
        chk("wrap_drained", 32'(count_o), 0);

        // Flush at 12 with a write and an unstalled read in the same cycle.
        for (int b = 0; b < 3; b++) wr(4'b1111, 1'b1, 1'b1);
        chk("flush_pre_count", 32'(count_o), 12);
        chk("flush_pre_rd_valid", 32'(rd_valid_o), 1);
        flush_i    = 1'b1;
        rd_stall_i = 1'b0;
        wr_valid_i = 4'b1111;
        #1;
        chk("flush_rd_valid", 32'(rd_valid_o), 0);
        exp_q.delete();
        @(posedge clk); #1;
        flush_i    = 1'b0;
        wr_valid_i = '0;
        chk("flush_count", 32'(count_o), 0);
        chk("flush_full", 32'(full_o), 0);

        // Asynchronous reset between edges at 17.
        for (int b = 0; b < 4; b++) wr(4'b1111, 1'b1, 1'b1);
        wr(4'b0001, 1'b1, 1'b1);
        chk("areset_pre_count", 32'(count_o), 17);
`ifdef INST_QUEUE_STATS_EN
        chk("stats_full_cycles", fullCycles_o, 2);
`endif
        #3;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("areset_count", 32'(count_o), 0);
        chk("areset_rd_valid", 32'(rd_valid_o), 0);
        chk("areset_full", 32'(full_o), 0);
`ifdef INST_QUEUE_STATS_EN
        chk("areset_full_cycles", fullCycles_o, 0);
        chk("areset_stall_cycles", stallCycles_o, 0);
`endif
        #2;
        reset = 1'b1;
        @(posedge clk); #1;

        wr(4'b1111, 1'b0, 1'b1);
        chk("post_reset_count", 32'(count_o), 4);
        idle(1);
        chk("post_reset_drained", 32'(count_o), 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
